// File: rtl/pre_comm_bp.sv
// Precommutator: steers per-lane requests into nPIPE commutator pipelines by channel address,
// with per-pipe valid/ready backpressure and a saturating counter of out-of-range drops.
module pre_comm_bp #(
  parameter int unsigned nIN   = 8,
  parameter int unsigned nOUT  = 52,
  parameter int unsigned wD    = 25,
  parameter int unsigned nPIPE = 4,
  parameter int unsigned wCNT  = 16,
  localparam int unsigned CH_PER_PIPE = (nOUT + nPIPE - 1) / nPIPE,
  localparam int unsigned wA_OUT      = $clog2(nOUT),
  localparam int unsigned wA_CH       = (CH_PER_PIPE > 1) ? $clog2(CH_PER_PIPE) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [nIN-1:0]          req_in,
  input  logic [wD*nIN-1:0]       data_in,
  input  logic [wA_OUT*nIN-1:0]   addr_in,
  output logic [nIN-1:0]          ready_in,
  output logic [nIN-1:0]          req_out  [nPIPE],
  output logic [wD*nIN-1:0]       data_out [nPIPE],
  output logic [wA_CH*nIN-1:0]    addr_out [nPIPE],
  input  logic [nIN-1:0]          ready_out [nPIPE],
  output logic [wCNT-1:0]         drop_cnt
);

  localparam int unsigned PW     = (nPIPE > 1) ? $clog2(nPIPE) : 1;
  localparam int unsigned INC_W  = $clog2(nIN + 1);
  localparam int unsigned CNT_W1 = wCNT + 1;

  logic [nIN-1:0]        s1_valid_q, s1_valid_d;
  logic [wD*nIN-1:0]     s1_data_q,  s1_data_d;
  logic [wA_OUT*nIN-1:0] s1_addr_q,  s1_addr_d;

  logic [nIN-1:0]        or_valid_q [nPIPE];
  logic [nIN-1:0]        or_valid_d [nPIPE];
  logic [wD*nIN-1:0]     or_data_q  [nPIPE];
  logic [wD*nIN-1:0]     or_data_d  [nPIPE];
  logic [wA_CH*nIN-1:0]  or_ch_q    [nPIPE];
  logic [wA_CH*nIN-1:0]  or_ch_d    [nPIPE];

  logic [wCNT-1:0]       drop_cnt_q, drop_cnt_d;

  logic [PW-1:0]         pipe_c [nIN];
  logic [wA_CH-1:0]      ch_c   [nIN];
  logic [nIN-1:0]        oor_c, free_c, adv_c, ready_c, drop_c;
  logic [INC_W-1:0]      drop_inc_c;
  logic [CNT_W1-1:0]     drop_sum_c;

  // Address decode by comparator chain, then per-lane advance/accept decisions
  always_comb begin
    for (int unsigned i = 0; i < nIN; i++) begin
      pipe_c[i] = '0;
      ch_c[i]   = wA_CH'(s1_addr_q[i*wA_OUT +: wA_OUT]);
      oor_c[i]  = 32'(s1_addr_q[i*wA_OUT +: wA_OUT]) >= nOUT;
      for (int unsigned p = 1; p < nPIPE; p++) begin
        if (32'(s1_addr_q[i*wA_OUT +: wA_OUT]) >= p * CH_PER_PIPE) begin
          pipe_c[i] = PW'(p);
          ch_c[i]   = wA_CH'(32'(s1_addr_q[i*wA_OUT +: wA_OUT]) - p * CH_PER_PIPE);
        end
      end
      free_c[i] = 1'b0;
      for (int unsigned p = 0; p < nPIPE; p++) begin
        if (pipe_c[i] == PW'(p)) begin
          free_c[i] = !or_valid_q[p][i] || ready_out[p][i];
        end
      end
      adv_c[i]   = s1_valid_q[i] && (oor_c[i] || free_c[i]);
      ready_c[i] = !s1_valid_q[i] || adv_c[i];
      drop_c[i]  = adv_c[i] && oor_c[i];
    end
  end

  // Next state for S1, output registers and the drop counter
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_addr_d  = s1_addr_q;
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_ch_d    = or_ch_q;
    drop_inc_c = '0;

    for (int unsigned p = 0; p < nPIPE; p++) begin
      for (int unsigned i = 0; i < nIN; i++) begin
        if (or_valid_q[p][i] && ready_out[p][i]) begin
          or_valid_d[p][i] = 1'b0;
        end
      end
    end

    for (int unsigned i = 0; i < nIN; i++) begin
      if (adv_c[i] && !oor_c[i]) begin
        for (int unsigned p = 0; p < nPIPE; p++) begin
          if (pipe_c[i] == PW'(p)) begin
            or_valid_d[p][i]              = 1'b1;
            or_data_d[p][i*wD +: wD]      = s1_data_q[i*wD +: wD];
            or_ch_d[p][i*wA_CH +: wA_CH]  = ch_c[i];
          end
        end
      end
      if (ready_c[i]) begin
        s1_valid_d[i] = req_in[i];
        if (req_in[i]) begin
          s1_data_d[i*wD +: wD]         = data_in[i*wD +: wD];
          s1_addr_d[i*wA_OUT +: wA_OUT] = addr_in[i*wA_OUT +: wA_OUT];
        end
      end
      drop_inc_c = drop_inc_c + INC_W'(drop_c[i]);
    end

    // One extra bit catches overflow; saturate instead of wrapping
    drop_sum_c = {1'b0, drop_cnt_q} + CNT_W1'(drop_inc_c);
    drop_cnt_d = drop_sum_c[wCNT] ? '1 : drop_sum_c[wCNT-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= '0;
      s1_data_q  <= '0;
      s1_addr_q  <= '0;
      drop_cnt_q <= '0;
      for (int unsigned p = 0; p < nPIPE; p++) begin
        or_valid_q[p] <= '0;
        or_data_q[p]  <= '0;
        or_ch_q[p]    <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_addr_q  <= s1_addr_d;
      drop_cnt_q <= drop_cnt_d;
      for (int unsigned p = 0; p < nPIPE; p++) begin
        or_valid_q[p] <= or_valid_d[p];
        or_data_q[p]  <= or_data_d[p];
        or_ch_q[p]    <= or_ch_d[p];
      end
    end
  end

  assign ready_in = ready_c;
  assign drop_cnt = drop_cnt_q;
  assign req_out  = or_valid_q;
  assign data_out = or_data_q;
  assign addr_out = or_ch_q;

endmodule

// File: tb/tb_pre_comm_bp.sv
// Bench for pre_comm_bp: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_pre_comm_bp;

  localparam int NIN = 2, NOUT = 50, WD = 25, NPIPE = 4, WCNT = 4;
  localparam int CPP = 13, WAO = 6, WAC = 4, CNT_MAX = 15;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NIN-1:0]       req_in = '0;
  logic [WD*NIN-1:0]    data_in = '0;
  logic [WAO*NIN-1:0]   addr_in = '0;
  logic [NIN-1:0]       ready_in;
  logic [NIN-1:0]       req_out  [NPIPE];
  logic [WD*NIN-1:0]    data_out [NPIPE];
  logic [WAC*NIN-1:0]   addr_out [NPIPE];
  logic [NIN-1:0]       ready_out [NPIPE];
  logic [WCNT-1:0]      drop_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit            m_s1v [NIN];
  int            m_s1a [NIN];
  logic [WD-1:0] m_s1d [NIN];
  bit            m_orv [NPIPE][NIN];
  logic [WD-1:0] m_ord [NPIPE][NIN];
  int            m_orc [NPIPE][NIN];
  int            m_cnt;

  logic [NIN-1:0]     e_rdy, e_req;
  logic [WD*NIN-1:0]  e_data;
  logic [WAC*NIN-1:0] e_addr;

  pre_comm_bp #(.nIN(NIN), .nOUT(NOUT), .wD(WD), .nPIPE(NPIPE), .wCNT(WCNT)) dut (
    .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in), .addr_in(addr_in),
    .ready_in(ready_in), .req_out(req_out), .data_out(data_out), .addr_out(addr_out),
    .ready_out(ready_out), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A lane's S1 can move on if empty, dropping, or its target pipe slot is free/draining
  function automatic bit m_ready(int i);
    int p;
    if (!m_s1v[i]) return 1'b1;
    if (m_s1a[i] >= NOUT) return 1'b1;
    p = m_s1a[i] / CPP;
    return !m_orv[p][i] || ready_out[p][i];
  endfunction

  task automatic m_step();
    bit rdy [NIN];
    int drops;
    int p;
    if (reset) begin
      for (int i = 0; i < NIN; i++) begin
        m_s1v[i] = 1'b0; m_s1a[i] = 0; m_s1d[i] = '0;
      end
      for (int q = 0; q < NPIPE; q++)
        for (int i = 0; i < NIN; i++) begin
          m_orv[q][i] = 1'b0; m_ord[q][i] = '0; m_orc[q][i] = 0;
        end
      m_cnt = 0;
      return;
    end
    for (int i = 0; i < NIN; i++) rdy[i] = m_ready(i);
    for (int q = 0; q < NPIPE; q++)
      for (int i = 0; i < NIN; i++)
        if (m_orv[q][i] && ready_out[q][i]) m_orv[q][i] = 1'b0;
    drops = 0;
    for (int i = 0; i < NIN; i++) begin
      if (m_s1v[i] && rdy[i]) begin
        if (m_s1a[i] >= NOUT) drops++;
        else begin
          p = m_s1a[i] / CPP;
          m_orv[p][i] = 1'b1;
          m_ord[p][i] = m_s1d[i];
          m_orc[p][i] = m_s1a[i] % CPP;
        end
      end
    end
    for (int i = 0; i < NIN; i++) begin
      if (rdy[i]) begin
        m_s1v[i] = req_in[i];
        if (req_in[i]) begin
          m_s1a[i] = int'(addr_in[i*WAO +: WAO]);
          m_s1d[i] = data_in[i*WD +: WD];
        end
      end
    end
    m_cnt = (m_cnt + drops > CNT_MAX) ? CNT_MAX : m_cnt + drops;
  endtask

  // Compare mid-cycle against the model, then advance the model to the coming edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NIN; i++) e_rdy[i] = m_ready(i);
      cmp("ready_in", 64'(ready_in), 64'(e_rdy));
      for (int q = 0; q < NPIPE; q++) begin
        for (int i = 0; i < NIN; i++) begin
          e_req[i] = m_orv[q][i];
          e_data[i*WD +: WD] = m_ord[q][i];
          e_addr[i*WAC +: WAC] = WAC'(m_orc[q][i]);
        end
        cmp($sformatf("req_out[%0d]", q), 64'(req_out[q]), 64'(e_req));
        cmp($sformatf("data_out[%0d]", q), 64'(data_out[q]), 64'(e_data));
        cmp($sformatf("addr_out[%0d]", q), 64'(addr_out[q]), 64'(e_addr));
      end
      cmp("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
    end
    m_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int lane, bit v, int a, logic [WD-1:0] d);
    req_in[lane] = v;
    addr_in[lane*WAO +: WAO] = WAO'(a);
    data_in[lane*WD +: WD] = d;
  endtask

  task automatic set_ready(bit v);
    for (int q = 0; q < NPIPE; q++) ready_out[q] = {NIN{v}};
  endtask

  initial begin
    set_ready(1'b1);
    reset = 1'b1;
    tick(); tick();
    chk_en = 1'b1;
    cmp("rst_ready_in", 64'(ready_in), 64'h3);
    cmp("rst_drop", 64'(drop_cnt), 64'h0);
    cmp("rst_req", 64'({req_out[0], req_out[1], req_out[2], req_out[3]}), 64'h0);
    reset = 1'b0;

    // Single request to address 27: pipe 2, channel 1, visible one edge after capture
    drive(0, 1'b1, 27, 25'h0ABCDE); tick();
    drive(0, 1'b0, 0, '0); tick();
    cmp("t1_req", 64'(req_out[2][0]), 64'h1);
    cmp("t1_ch", 64'(addr_out[2][3:0]), 64'h1);
    cmp("t1_data", 64'(data_out[2][24:0]), 64'h0ABCDE);
    tick();
    cmp("t1_once", 64'(req_out[2][0]), 64'h0);

    // Back-to-back on lane 1: last channel of the short last pipe, then channel 0
    drive(1, 1'b1, 49, 25'h1111); tick();
    drive(1, 1'b1, 0, 25'h2222); tick();
    cmp("t2_p3_req", 64'(req_out[3][1]), 64'h1);
    cmp("t2_p3_ch", 64'(addr_out[3][7:4]), 64'd10);
    drive(1, 1'b0, 0, '0); tick();
    cmp("t2_p0_req", 64'(req_out[0][1]), 64'h1);
    cmp("t2_p0_ch", 64'(addr_out[0][7:4]), 64'h0);
    cmp("t2_p0_data", 64'(data_out[0][49:25]), 64'h2222);
    cmp("t2_p3_gone", 64'(req_out[3][1]), 64'h0);
    tick();

    // Out-of-range address is dropped and counted
    drive(0, 1'b1, 50, 25'h3333); tick();
    drive(0, 1'b0, 0, '0); #1;
    cmp("t3_ready", 64'(ready_in[0]), 64'h1);
    tick();
    cmp("t3_drop", 64'(drop_cnt), 64'h1);
    cmp("t3_noreq", 64'({req_out[0], req_out[1], req_out[2], req_out[3]}), 64'h0);

    // Backpressure on pipe 1 lane 0, then in-order release
    ready_out[1][0] = 1'b0;
    drive(0, 1'b1, 13, 25'h13); tick();
    drive(0, 1'b1, 14, 25'h14); tick();
    drive(0, 1'b1, 15, 25'h15); #1;
    cmp("t4_stall", 64'(ready_in[0]), 64'h0);
    tick();
    cmp("t4_held_req", 64'(req_out[1][0]), 64'h1);
    cmp("t4_held_ch", 64'(addr_out[1][3:0]), 64'h0);
    cmp("t4_held_data", 64'(data_out[1][24:0]), 64'h13);
    tick();
    cmp("t4_stable_data", 64'(data_out[1][24:0]), 64'h13);
    ready_out[1][0] = 1'b1; #1;
    cmp("t4_release", 64'(ready_in[0]), 64'h1);
    tick();
    drive(0, 1'b0, 0, '0);
    cmp("t4_ch1", 64'(addr_out[1][3:0]), 64'h1);
    cmp("t4_d1", 64'(data_out[1][24:0]), 64'h14);
    tick();
    cmp("t4_ch2", 64'(addr_out[1][3:0]), 64'h2);
    cmp("t4_d2", 64'(data_out[1][24:0]), 64'h15);
    tick();
    cmp("t4_done", 64'(req_out[1][0]), 64'h0);

    // Counter saturation with both lanes dropping every cycle
    reset = 1'b1; tick(); reset = 1'b0;
    drive(0, 1'b1, 55, 25'h1); drive(1, 1'b1, 63, 25'h2);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 5) cmp("t5_mid", 64'(drop_cnt), 64'd8);
    end
    cmp("t5_sat", 64'(drop_cnt), 64'd15);
    cmp("t5_ready", 64'(ready_in), 64'h3);
    drive(0, 1'b0, 0, '0); drive(1, 1'b0, 0, '0);
    tick();
    cmp("t5_hold", 64'(drop_cnt), 64'd15);

    // Reset while S1 and output registers are full
    reset = 1'b1; tick(); reset = 1'b0;
    set_ready(1'b0);
    drive(0, 1'b1, 5, 25'h1AAAAAA); drive(1, 1'b1, 20, 25'h0555555);
    tick(); tick(); #1;
    cmp("t6_full", 64'(ready_in), 64'h0);
    cmp("t6_or", 64'(req_out[0][0]), 64'h1);
    reset = 1'b1; tick(); reset = 1'b0;
    drive(0, 1'b0, 0, '0); drive(1, 1'b0, 0, '0);
    cmp("t6_req", 64'({req_out[0], req_out[1], req_out[2], req_out[3]}), 64'h0);
    cmp("t6_drop", 64'(drop_cnt), 64'h0);
    cmp("t6_ready", 64'(ready_in), 64'h3);
    cmp("t6_data", 64'(data_out[0]), 64'h0);
    set_ready(1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      cmp("t6_quiet", 64'({req_out[0], req_out[1], req_out[2], req_out[3]}), 64'h0);
    end

    // Randomized traffic, backpressure and occasional reset
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NIN; i++)
        drive(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), WD'($urandom()));
      for (int q = 0; q < NPIPE; q++)
        for (int i = 0; i < NIN; i++)
          ready_out[q][i] = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0;
    req_in = '0;
    set_ready(1'b1);
    tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
